// File: rtl/key_press_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: per-key debounce
// state encoding and the default debounce period.
package key_press_conditioner_pkg;

   // Per-key debounce state. The encoding is fixed so the state is easy to
   // read from a debug probe.
   typedef enum logic [1:0] {
      RELEASED        = 2'd0,
      PRESS_PENDING   = 2'd1,
      PRESSED         = 2'd2,
      RELEASE_PENDING = 2'd3
   } key_state_t;

   // 10 ms of stability at a 50 MHz clock.
   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/key_press_conditioner_if.sv
// Bundle of the board-side button vector and the conditioned outputs.
//
// Signalling: there is no valid/ready pair on this bundle. `key` is a
// one-cycle strobe that the consumer must take in the cycle it is high;
// there is no backpressure and no stall. `key_level` and `key_state` are
// plain levels that can be sampled at any time.
interface key_press_conditioner_if #(
   parameter int NUM_KEYS = 4
);
   logic [NUM_KEYS-1:0]      raw_keys;   // active-low board buttons
   logic [NUM_KEYS-1:0]      key;        // one-cycle press pulses
   logic [NUM_KEYS-1:0]      key_level;  // debounced pressed level
   logic                     any_press;  // OR of key, same cycle
   logic [NUM_KEYS-1:0][1:0] key_state;  // per-key debounce state (debug)

   // Board/testbench side.
   modport master (
      output raw_keys,
      input  key,
      input  key_level,
      input  any_press,
      input  key_state
   );

   // Conditioner side.
   modport slave (
      input  raw_keys,
      output key,
      output key_level,
      output any_press,
      output key_state
   );
endinterface

// File: rtl/key_press_conditioner_debouncer.sv
// Single-button conditioner: 2-flop synchronizer, four-state debounce FSM
// and stability counter. Produces a one-cycle press pulse and a debounced
// level; releases never pulse.
module key_debouncer
   import key_press_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       raw_key,  // active-low, asynchronous
   output logic       pulse,    // registered one-cycle press pulse
   output logic       level,    // registered debounced level
   output logic       accept,   // next-cycle value of pulse
   output key_state_t state     // current debounce state
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [1:0]       sync_ff;
   logic             sync;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchronizer, reset to the released (high) level.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) sync_ff <= 2'b11;
      else        sync_ff <= {sync_ff[0], raw_key};
   end

   assign sync = sync_ff[1];

   // A press is accepted in the cycle the pending count reaches its limit
   // with the button still down; pulse is this value one cycle later.
   assign accept = (state == PRESS_PENDING) && !sync && (cnt == CNT_MAX);

   // Debounce FSM with counter; pulse and level are registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= RELEASED;
         cnt   <= '0;
         pulse <= 1'b0;
         level <= 1'b0;
      end else begin
         pulse <= 1'b0;
         case (state)
            RELEASED: begin
               if (!sync) begin
                  state <= PRESS_PENDING;
                  cnt   <= CNT_W'(1);
               end
            end
            PRESS_PENDING: begin
               if (sync) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  state <= PRESSED;
                  pulse <= 1'b1;
                  level <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (sync) begin
                  state <= RELEASE_PENDING;
                  cnt   <= CNT_W'(1);
               end
            end
            RELEASE_PENDING: begin
               if (!sync) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  state <= RELEASED;
                  level <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_press_conditioner.sv
// Turns the bouncing active-low DE1-SoC push-buttons into clean,
// active-high one-cycle press pulses for the lock FSM. Each button has its
// own debouncer; this level only gathers the per-key outputs and registers
// any_press so it lines up with key.
module key_press_conditioner
   import key_press_conditioner_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input logic                    clock,
   input logic                    reset,
   key_press_conditioner_if.slave bus
);

   logic [NUM_KEYS-1:0] pulse_vec;
   logic [NUM_KEYS-1:0] level_vec;
   logic [NUM_KEYS-1:0] accept_vec;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_state_t key_st;

      key_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
         .clock  (clock),
         .reset  (reset),
         .raw_key(bus.raw_keys[i]),
         .pulse  (pulse_vec[i]),
         .level  (level_vec[i]),
         .accept (accept_vec[i]),
         .state  (key_st)
      );

      assign bus.key_state[i] = key_st;
   end

   assign bus.key       = pulse_vec;
   assign bus.key_level = level_vec;

   // any_press is registered from the same next-cycle terms as key, so it
   // rises and falls in exactly the cycles key is non-zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) bus.any_press <= 1'b0;
      else        bus.any_press <= |accept_vec;
   end

endmodule

// File: tb/tb_key_press_conditioner.sv
// Directed bench for key_press_conditioner with a short debounce period.
// Expected pulses (cycle and key vector) are queued by the stimulus and
// consumed by a negedge monitor; level edges are timed by the monitor too.
module tb_key_press_conditioner;

  localparam int NK  = 4;
  localparam int DB  = 4;
  // Drive cycle to pulse cycle: one cycle to reach the first sampling edge,
  // two synchronizer flops, DB counting steps, one register.
  localparam int LAT = DB + 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [35:0]   exp_q[$];
  logic [35:0]   mon_e;
  logic [NK-1:0] prev_key;
  logic [NK-1:0] prev_level;
  int            lvl_rise[NK];
  int            lvl_fall[NK];
  int            rise_cnt[NK];
  int            t;
  int            r;

  key_press_conditioner_if #(.NUM_KEYS(NK)) kif ();

  key_press_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (kif.slave)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic [NK-1:0] v);
    @(posedge clock);
    #1;
    kif.raw_keys = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_reset(input logic v);
    @(posedge clock);
    #1;
    reset = v;
  endtask

  task automatic expect_pulse(input int at, input logic [NK-1:0] v);
    exp_q.push_back({32'(at), v});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!reset) begin
      check("rst_key", 32'(kif.key), 32'd0);
      check("rst_level", 32'(kif.key_level), 32'd0);
      check("rst_any", 32'(kif.any_press), 32'd0);
    end
    check("any_press", 32'(kif.any_press), 32'(|kif.key));
    check("pulse_width", 32'(kif.key & prev_key), 32'd0);
    if (kif.key != '0) begin
      if (exp_q.size() == 0) begin
        check("unexp_pulse", 32'(kif.key), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_vec", 32'(kif.key), 32'(mon_e[NK-1:0]));
        check("pulse_cyc", 32'(cyc), mon_e[35:4]);
      end
    end
    for (int i = 0; i < NK; i++) begin
      if (kif.key_level[i] && !prev_level[i]) begin
        lvl_rise[i] = cyc;
        rise_cnt[i]++;
      end
      if (!kif.key_level[i] && prev_level[i]) lvl_fall[i] = cyc;
    end
    prev_key   = kif.key;
    prev_level = kif.key_level;
  end

  // ---------------- stimulus ----------------
  initial begin
    kif.raw_keys = '1;
    prev_key     = '0;
    prev_level   = '0;
    for (int i = 0; i < NK; i++) begin
      lvl_rise[i] = 0;
      lvl_fall[i] = 0;
      rise_cnt[i] = 0;
    end

    // 1: reset held while buttons chatter, then released with all up
    repeat (10) drive(4'($urandom_range(0, 15)));
    drive('1);
    set_reset(1'b1);
    idle(10);
    check("t1_level", 32'(kif.key_level), 32'd0);

    // 2: clean press of key 2 for 20 cycles, then clean release
    drive(4'b1011);
    t = cyc;
    expect_pulse(t + LAT, 4'b0100);
    idle(19);
    drive('1);
    r = cyc;
    idle(12);
    check("t2_rise", 32'(lvl_rise[2]), 32'(t + LAT));
    check("t2_fall", 32'(lvl_fall[2]), 32'(r + LAT));
    check("t2_rise_cnt", 32'(rise_cnt[2]), 32'd1);

    // 3: key 0 low 3, high 1, then low 12 -> one pulse from second fall
    drive(4'b1110);
    idle(2);
    drive(4'b1111);
    drive(4'b1110);
    t = cyc;
    expect_pulse(t + LAT, 4'b0001);
    idle(11);
    check("t3_rise", 32'(lvl_rise[0]), 32'(t + LAT));
    check("t3_rise_cnt", 32'(rise_cnt[0]), 32'd1);
    check("t3_level", 32'(kif.key_level), 32'h1);

    // 4: release with bounce: high 2, low 1, high 10
    drive(4'b1111);
    idle(1);
    drive(4'b1110);
    drive(4'b1111);
    r = cyc;
    idle(9);
    check("t4_fall", 32'(lvl_fall[0]), 32'(r + LAT));
    check("t4_level", 32'(kif.key_level), 32'd0);
    // lone 3-cycle glitch is rejected
    drive(4'b1110);
    idle(2);
    drive(4'b1111);
    idle(10);
    check("t4_glitch_rise_cnt", 32'(rise_cnt[0]), 32'd1);
    check("t4_glitch_level", 32'(kif.key_level), 32'd0);

    // 5: keys 0 and 3 together, key 1 two cycles later
    drive(4'b0110);
    t = cyc;
    expect_pulse(t + LAT, 4'b1001);
    idle(1);
    drive(4'b0100);
    expect_pulse(cyc + LAT, 4'b0010);
    idle(14);
    check("t5_level", 32'(kif.key_level), 32'hB);
    check("t5_gap", 32'(lvl_rise[1] - lvl_rise[0]), 32'd2);
    drive('1);
    idle(12);
    check("t5_rel_level", 32'(kif.key_level), 32'd0);

    // 6: reset pulsed while key 1 is held; full debounce after release
    drive(4'b1101);
    idle(1);
    set_reset(1'b0);
    idle(3);
    check("t6_rst_state", 32'(kif.key_state), 32'd0);
    set_reset(1'b1);
    r = cyc;
    expect_pulse(r + LAT, 4'b0010);
    idle(15);
    check("t6_rise", 32'(lvl_rise[1]), 32'(r + LAT));
    check("t6_level", 32'(kif.key_level), 32'h2);
    drive('1);
    idle(12);
    check("t6_rel_level", 32'(kif.key_level), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
